// File: rtl/ring_buffer_i2s_reader_pkg.sv
// Shared types and limits for the ring_buffer I2S read side.
package ring_buffer_i2s_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LATCH
  } reader_state_t;

  localparam int unsigned BCLK_DIV_MIN = 2;

endpackage

// File: rtl/ring_buffer_i2s_reader_if.sv
// Pop handshake between ring_buffer (slave) and its reader (master).
interface ring_buffer_i2s_reader_if #(
  parameter int unsigned WIDTH = 8
);

  logic             empty;
  logic [WIDTH-1:0] data_out;
  logic             read_enable;

  modport master (
    output read_enable,
    input  empty,
    input  data_out
  );

  modport slave (
    input  read_enable,
    output empty,
    output data_out
  );

endinterface

// File: rtl/ring_buffer_i2s_reader_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles; fall_stb marks
// the cycle whose closing edge drives bclk from 1 to 0.
module bclk_gen
  import ring_buffer_i2s_reader_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_stb
);

  // Values below the minimum leave no room for the 2-clk fetch, so clamp.
  localparam int unsigned DIV = (BCLK_DIV < BCLK_DIV_MIN) ? BCLK_DIV_MIN : BCLK_DIV;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Half-period counter and bclk toggle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign fall_stb = bclk && (div_cnt == DIV_LAST);

endmodule

// File: rtl/ring_buffer_i2s_reader.sv
// Read side of ring_buffer: fetches one sample per frame and serialises it
// MSB first, left-justified, on both left and right slots.
module ring_buffer_i2s_reader
  import ring_buffer_i2s_reader_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned BCLK_DIV = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  ring_buffer_i2s_reader_if.master        rb,
  output logic                            bclk,
  output logic                            lrclk,
  output logic                            sdata,
  output logic                            underrun
);

  localparam int unsigned BW = $clog2(2 * WIDTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * WIDTH - 1);
  localparam logic [BW-1:0] BIT_RIGHT = BW'(WIDTH);

  logic             fall_stb;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [WIDTH-1:0] shift_l;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] held;
  reader_state_t    state;

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst      (rst),
    .bclk     (bclk),
    .fall_stb (fall_stb)
  );

  // Bit position the next falling edge moves to.
  always_comb begin
    bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  end

  // Slot framing and shift registers, advanced only on bclk falling edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      shift_l <= '0;
      shift_r <= '0;
    end else if (fall_stb) begin
      bit_cnt <= bit_nxt;
      if (bit_nxt == '0) begin
        shift_l <= held;
        shift_r <= held;
      end else if (bit_nxt < BIT_RIGHT) begin
        shift_l <= {shift_l[WIDTH-2:0], 1'b0};
      end else if (bit_nxt > BIT_RIGHT) begin
        shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign lrclk = (bit_cnt >= BIT_RIGHT);
  assign sdata = lrclk ? shift_r[WIDTH-1] : shift_l[WIDTH-1];

  // Fetch FSM: one pop attempt per frame, launched on the last bit's edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      held  <= '0;
    end else begin
      case (state)
        IDLE:    if (fall_stb && (bit_nxt == BIT_LAST)) state <= REQ;
        REQ:     state <= rb.empty ? IDLE : LATCH;
        LATCH: begin
          held  <= rb.data_out;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // empty is only valid to sample in REQ itself, so the pop and underrun
  // pulses are decoded from that state rather than registered a cycle early;
  // gating with rst keeps a reset cycle from issuing a pop.
  assign rb.read_enable = rst && (state == REQ) && !rb.empty;
  assign underrun       = rst && (state == REQ) && rb.empty;

endmodule
